datapath_controller: RTL and testbench

Control unit for the Simple RISC Machine. Holds the 16-bit instruction register and decodes its fields. A Moore state machine then sequences the datapath's control strobes (register-file read/write, A/B/C/status loads, operand selects, ALU op, shift) for one instruction at a time. It sits in front of `datapath` and drives every one of its control and immediate inputs; `datapath` only returns `C` and status.

---
 rtl/rsm_pkg.sv | 40 ++++
 rtl/instr_decoder.sv | 23 ++
 rtl/datapath_controller.sv | 135 +++++++++++++
 tb/tb_datapath_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsm_pkg.sv
// Shared types and encodings for the Simple RISC Machine control unit.
package rsm_pkg;

   typedef enum logic [2:0] {
      WAIT      = 3'd0,
      DECODE    = 3'd1,
      GET_A     = 3'd2,
      GET_B     = 3'd3,
      ALU       = 3'd4,
      WRITE_REG = 3'd5,
      WRITE_IMM = 3'd6
   } state_t;

   localparam logic [2:0] OPC_MOV = 3'b110;
   localparam logic [2:0] OPC_ALU = 3'b101;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;

   localparam logic [1:0] VSEL_MDATA = 2'b00;
   localparam logic [1:0] VSEL_C     = 2'b01;
   localparam logic [1:0] VSEL_IMM8  = 2'b10;
   localparam logic [1:0] VSEL_PC    = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;

   // MOV only has the imm8 (10) and register (00) forms; every ALU op is defined.
   function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] op);
      return (opcode == OPC_ALU) ||
             (opcode == OPC_MOV && (op == OP_MOV_IMM || op == OP_MOV_REG));
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the instruction register into its fields and immediates.
module instr_decoder (
   input  logic [15:0] ir,
   output logic [2:0]  opcode,
   output logic [1:0]  op,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [2:0]  rm,
   output logic [1:0]  shift,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5
);

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign shift  = ir[4:3];
   assign rm     = ir[2:0];
   assign sximm8 = {{8{ir[7]}}, ir[7:0]};
   assign sximm5 = {{11{ir[4]}}, ir[4:0]};

endmodule

// File: rtl/datapath_controller.sv
// Instruction register plus Moore FSM that sequences the datapath strobes
// for one instruction at a time; `state` exposes the FSM for observation.
module datapath_controller
   import rsm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic [1:0]  vsel,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output state_t      state
);

   state_t      next_state;
   logic [15:0] ir;
   logic [2:0]  opcode;
   logic [1:0]  op;
   logic [2:0]  rn;
   logic [2:0]  rd;
   logic [2:0]  rm;
   logic [1:0]  ir_shift;
   logic        is_mov_imm;
   logic        is_mov_reg;
   logic        is_cmp;

   instr_decoder u_dec (
      .ir     (ir),
      .opcode (opcode),
      .op     (op),
      .rn     (rn),
      .rd     (rd),
      .rm     (rm),
      .shift  (ir_shift),
      .sximm8 (sximm8),
      .sximm5 (sximm5)
   );

   assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
   assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
   assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);

   // IR only loads in WAIT so the fields stay stable for the whole instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir <= 16'h0000;
      end else if (state == WAIT && load) begin
         ir <= in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= WAIT;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      w          = 1'b0;
      readnum    = 3'd0;
      writenum   = 3'd0;
      write      = 1'b0;
      vsel       = VSEL_MDATA;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      shift      = 2'b00;
      ALUop      = ALU_ADD;
      case (state)
         WAIT: begin
            w = 1'b1;
            if (s) next_state = DECODE;
         end
         DECODE: begin
            if (!is_legal(opcode, op)) next_state = WAIT;
            else if (is_mov_imm)       next_state = WRITE_IMM;
            else if (is_mov_reg)       next_state = GET_B;
            else                       next_state = GET_A;
         end
         GET_A: begin
            readnum    = rn;
            loada      = 1'b1;
            next_state = GET_B;
         end
         GET_B: begin
            readnum    = rm;
            loadb      = 1'b1;
            next_state = ALU;
         end
         ALU: begin
            // MOV reg is computed as 0 + shifted Rm.
            shift      = ir_shift;
            loadc      = 1'b1;
            asel       = is_mov_reg;
            ALUop      = is_mov_reg ? ALU_ADD : op;
            loads      = is_cmp;
            next_state = is_cmp ? WAIT : WRITE_REG;
         end
         WRITE_REG: begin
            writenum   = rd;
            vsel       = VSEL_C;
            write      = 1'b1;
            next_state = WAIT;
         end
         WRITE_IMM: begin
            writenum   = rn;
            vsel       = VSEL_IMM8;
            write      = 1'b1;
            next_state = WAIT;
         end
         default: next_state = WAIT;
      endcase
   end

endmodule

// File: tb/tb_datapath_controller.sv
// Cycle-by-cycle directed bench for datapath_controller.
module tb_datapath_controller;
   import rsm_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [15:0] in;
   logic        load;
   logic        s;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic [1:0]  vsel;
   logic        loada;
   logic        loadb;
   logic        loadc;
   logic        loads;
   logic        asel;
   logic        bsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;
   logic [15:0] sximm5;
   state_t      state;

   typedef struct packed {
      logic       w;
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic       write;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] shift;
      logic [1:0] alu_op;
   } ctl_t;

   typedef struct {
      logic        rst_n;
      logic        load;
      logic        s;
      logic [15:0] in;
      state_t      st;
      ctl_t        ctl;
      logic [15:0] imm8;
      logic [15:0] imm5;
   } vec_t;

   int   errors = 0;
   int   checks = 0;
   int   write_count = 0;
   vec_t vq[$];

   datapath_controller dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in),
      .load     (load),
      .s        (s),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .vsel     (vsel),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel),
      .shift    (shift),
      .ALUop    (ALUop),
      .sximm8   (sximm8),
      .sximm5   (sximm5),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (write) write_count++;

   // Expected strobe patterns, one constructor per state shape.
   function automatic ctl_t c_idle();
      ctl_t c = '0;
      c.w = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_zero();
      return '0;
   endfunction
   function automatic ctl_t c_imm(input logic [2:0] wn);
      ctl_t c = '0;
      c.writenum = wn; c.vsel = 2'b10; c.write = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_geta(input logic [2:0] rn);
      ctl_t c = '0;
      c.readnum = rn; c.loada = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_getb(input logic [2:0] rn);
      ctl_t c = '0;
      c.readnum = rn; c.loadb = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_alu(input logic [1:0] sh, input logic [1:0] op,
                                  input logic as, input logic ls);
      ctl_t c = '0;
      c.shift = sh; c.alu_op = op; c.asel = as; c.loads = ls; c.loadc = 1'b1;
      return c;
   endfunction
   function automatic ctl_t c_wr(input logic [2:0] wn);
      ctl_t c = '0;
      c.writenum = wn; c.vsel = 2'b01; c.write = 1'b1;
      return c;
   endfunction

   function automatic vec_t v(input logic r, input logic ld, input logic st_in,
                              input logic [15:0] instr, input state_t st, input ctl_t c,
                              input logic [15:0] i8, input logic [15:0] i5);
      vec_t x;
      x.rst_n = r; x.load = ld; x.s = st_in; x.in = instr;
      x.st = st; x.ctl = c; x.imm8 = i8; x.imm5 = i5;
      return x;
   endfunction

   function automatic ctl_t observed();
      ctl_t c;
      c.w = w; c.readnum = readnum; c.writenum = writenum; c.write = write;
      c.vsel = vsel; c.loada = loada; c.loadb = loadb; c.loadc = loadc;
      c.loads = loads; c.asel = asel; c.bsel = bsel; c.shift = shift; c.alu_op = ALUop;
      return c;
   endfunction

   task automatic compare(input string name, input state_t st, input ctl_t c,
                          input logic [15:0] i8, input logic [15:0] i5);
      ctl_t got = observed();
      checks++;
      if (state !== st || got !== c || sximm8 !== i8 || sximm5 !== i5) begin
         errors++;
         $display("FAIL %s: got state=%0d ctl=%h sximm8=%h sximm5=%h, expected state=%0d ctl=%h sximm8=%h sximm5=%h",
                  name, state, got, sximm8, sximm5, st, c, i8, i5);
      end
   endtask

   task automatic step(input vec_t x, input string name);
      @(negedge clk);
      rst_n = x.rst_n; load = x.load; s = x.s; in = x.in;
      @(posedge clk);
      #1;
      compare(name, x.st, x.ctl, x.imm8, x.imm5);
   endtask

   task automatic check_writes(input string name, input int exp);
      checks++;
      if (write_count != exp) begin
         errors++;
         $display("FAIL %s: write pulses=%0d, expected %0d", name, write_count, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; s = 1'b0; in = 16'h0000;

      // Reset applied before any clock edge must already give the WAIT decode.
      #3;
      compare("reset_async", WAIT, c_idle(), 16'h0000, 16'h0000);

      vq.push_back(v(0, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0000, 16'h0000));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0000, 16'h0000));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0000, 16'h0000));
      // MOV R0,#7
      vq.push_back(v(1, 1, 1, 16'hD007, DECODE,    c_zero(),           16'h0007, 16'h0007));
      vq.push_back(v(1, 0, 0, 16'h0000, WRITE_IMM, c_imm(3'd0),        16'h0007, 16'h0007));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0007, 16'h0007));
      // MOV R1,#-2
      vq.push_back(v(1, 1, 1, 16'hD1FE, DECODE,    c_zero(),           16'hFFFE, 16'hFFFE));
      vq.push_back(v(1, 0, 0, 16'h0000, WRITE_IMM, c_imm(3'd1),        16'hFFFE, 16'hFFFE));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'hFFFE, 16'hFFFE));
      // ADD R2,R1,R0,LSL#1
      vq.push_back(v(1, 1, 1, 16'hA148, DECODE,    c_zero(),           16'h0048, 16'h0008));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_A,     c_geta(3'd1),       16'h0048, 16'h0008));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_B,     c_getb(3'd0),       16'h0048, 16'h0008));
      vq.push_back(v(1, 0, 0, 16'h0000, ALU,       c_alu(2'b01, 2'b00, 0, 0), 16'h0048, 16'h0008));
      vq.push_back(v(1, 0, 0, 16'h0000, WRITE_REG, c_wr(3'd2),         16'h0048, 16'h0008));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0048, 16'h0008));
      // CMP R1,R0
      vq.push_back(v(1, 1, 1, 16'hA900, DECODE,    c_zero(),           16'h0000, 16'h0000));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_A,     c_geta(3'd1),       16'h0000, 16'h0000));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_B,     c_getb(3'd0),       16'h0000, 16'h0000));
      vq.push_back(v(1, 0, 0, 16'h0000, ALU,       c_alu(2'b00, 2'b01, 0, 1), 16'h0000, 16'h0000));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0000, 16'h0000));
      // MOV R3,R2,LSR#1
      vq.push_back(v(1, 1, 1, 16'hC072, DECODE,    c_zero(),           16'h0072, 16'hFFF2));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_B,     c_getb(3'd2),       16'h0072, 16'hFFF2));
      vq.push_back(v(1, 0, 0, 16'h0000, ALU,       c_alu(2'b10, 2'b00, 1, 0), 16'h0072, 16'hFFF2));
      vq.push_back(v(1, 0, 0, 16'h0000, WRITE_REG, c_wr(3'd3),         16'h0072, 16'hFFF2));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0072, 16'hFFF2));
      // AND R5,R4,R3
      vq.push_back(v(1, 1, 1, 16'hB4A3, DECODE,    c_zero(),           16'hFFA3, 16'h0003));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_A,     c_geta(3'd4),       16'hFFA3, 16'h0003));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_B,     c_getb(3'd3),       16'hFFA3, 16'h0003));
      vq.push_back(v(1, 0, 0, 16'h0000, ALU,       c_alu(2'b00, 2'b10, 0, 0), 16'hFFA3, 16'h0003));
      vq.push_back(v(1, 0, 0, 16'h0000, WRITE_REG, c_wr(3'd5),         16'hFFA3, 16'h0003));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'hFFA3, 16'h0003));
      // MVN R7,R7,LSL#1
      vq.push_back(v(1, 1, 1, 16'hB8EF, DECODE,    c_zero(),           16'hFFEF, 16'h000F));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_A,     c_geta(3'd0),       16'hFFEF, 16'h000F));
      vq.push_back(v(1, 0, 0, 16'h0000, GET_B,     c_getb(3'd7),       16'hFFEF, 16'h000F));
      vq.push_back(v(1, 0, 0, 16'h0000, ALU,       c_alu(2'b01, 2'b11, 0, 0), 16'hFFEF, 16'h000F));
      vq.push_back(v(1, 0, 0, 16'h0000, WRITE_REG, c_wr(3'd7),         16'hFFEF, 16'h000F));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'hFFEF, 16'h000F));
      // Illegal opcode 111, then illegal MOV form 110/01
      vq.push_back(v(1, 1, 1, 16'hE123, DECODE,    c_zero(),           16'h0023, 16'h0003));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0023, 16'h0003));
      vq.push_back(v(1, 1, 1, 16'hC800, DECODE,    c_zero(),           16'h0000, 16'h0000));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0000, 16'h0000));
      // load without s captures IR but stays in WAIT
      vq.push_back(v(1, 1, 0, 16'hD30A, WAIT,      c_idle(),           16'h000A, 16'h000A));
      // s held high: back-to-back MOV R2,#5 with one WAIT cycle between
      vq.push_back(v(1, 1, 1, 16'hD205, DECODE,    c_zero(),           16'h0005, 16'h0005));
      vq.push_back(v(1, 0, 1, 16'h0000, WRITE_IMM, c_imm(3'd2),        16'h0005, 16'h0005));
      vq.push_back(v(1, 0, 1, 16'h0000, WAIT,      c_idle(),           16'h0005, 16'h0005));
      vq.push_back(v(1, 0, 1, 16'h0000, DECODE,    c_zero(),           16'h0005, 16'h0005));
      vq.push_back(v(1, 0, 0, 16'h0000, WRITE_IMM, c_imm(3'd2),        16'h0005, 16'h0005));
      vq.push_back(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),           16'h0005, 16'h0005));

      for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i));

      // load of FFFF from GET_A onwards must not disturb the ADD in flight.
      step(v(1, 1, 1, 16'hA148, DECODE,    c_zero(),       16'h0048, 16'h0008), "ign_decode");
      step(v(1, 0, 0, 16'h0000, GET_A,     c_geta(3'd1),   16'h0048, 16'h0008), "ign_geta");
      step(v(1, 1, 0, 16'hFFFF, GET_B,     c_getb(3'd0),   16'h0048, 16'h0008), "ign_getb");
      step(v(1, 1, 0, 16'hFFFF, ALU,       c_alu(2'b01, 2'b00, 0, 0), 16'h0048, 16'h0008), "ign_alu");
      step(v(1, 1, 0, 16'hFFFF, WRITE_REG, c_wr(3'd2),     16'h0048, 16'h0008), "ign_write");
      step(v(1, 0, 0, 16'h0000, WAIT,      c_idle(),       16'h0048, 16'h0008), "ign_wait");

      // Reset pulse during GET_B aborts the ADD with no write.
      step(v(1, 1, 1, 16'hA148, DECODE,    c_zero(),       16'h0048, 16'h0008), "abort_decode");
      step(v(1, 0, 0, 16'h0000, GET_A,     c_geta(3'd1),   16'h0048, 16'h0008), "abort_geta");
      step(v(1, 0, 0, 16'h0000, GET_B,     c_getb(3'd0),   16'h0048, 16'h0008), "abort_getb");
      write_count = 0;
      #2 rst_n = 1'b0;
      #1 compare("abort_async", WAIT, c_idle(), 16'h0000, 16'h0000);
      step(v(1, 0, 0, 16'h0000, WAIT, c_idle(), 16'h0000, 16'h0000), "abort_wait0");
      step(v(1, 0, 0, 16'h0000, WAIT, c_idle(), 16'h0000, 16'h0000), "abort_wait1");
      step(v(1, 0, 0, 16'h0000, WAIT, c_idle(), 16'h0000, 16'h0000), "abort_wait2");
      check_writes("abort_no_write", 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
